// File: rtl/popcount_pkg.sv
// Shared types and elaboration-time helpers for the serial popcount block.
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational population count of one CHUNK-bit slice.
module popcount_chunk
    import popcount_pkg::*;
#(
    parameter  int CHUNK = 3,
    localparam int KW    = clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] bits,
    output logic [KW-1:0]    cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < CHUNK; i++) begin
            cnt = cnt + KW'(bits[i]);
        end
    end

endmodule

// File: rtl/popcount_serial.sv
// Serial popcount: accepts one operand, counts CHUNK bits per clock, then
// presents the total until the consumer takes it.
module popcount_serial
    import popcount_pkg::*;
#(
    parameter  int WIDTH = 15,
    parameter  int CHUNK = 3,
    localparam int CW    = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data,
    input  logic             count_zeros,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    localparam int NCH = ceil_div(WIDTH, CHUNK);
    localparam int PW  = NCH * CHUNK;
    localparam int IW  = (NCH > 1) ? clog2(NCH) : 1;
    localparam int KW  = clog2(CHUNK + 1);

    state_t          state, state_nx;
    logic [PW-1:0]   op_q;
    logic [IW-1:0]   idx_q;
    logic [CW-1:0]   acc_q;
    logic [CW-1:0]   count_q;
    logic [KW-1:0]   chunk_cnt;
    logic [WIDTH-1:0] opnd;
    logic            last_chunk;

    // Inversion happens at capture, so zero-counting reuses the ones counter;
    // the padding above WIDTH is zero-filled and contributes nothing.
    assign opnd       = count_zeros ? ~data : data;
    assign last_chunk = (idx_q == IW'(NCH - 1));

    popcount_chunk #(.CHUNK(CHUNK)) u_chunk (
        .bits (op_q[CHUNK-1:0]),
        .cnt  (chunk_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)   state_nx = COUNT;
            COUNT:   if (last_chunk) state_nx = DONE;
            DONE:    if (out_ready)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The operand shifts down one chunk per cycle, so the chunk at idx is
    // always in the low CHUNK bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q  <= PW'(opnd);
                        idx_q <= '0;
                        acc_q <= '0;
                    end
                end
                COUNT: begin
                    op_q  <= op_q >> CHUNK;
                    idx_q <= idx_q + IW'(1);
                    acc_q <= acc_q + CW'(chunk_cnt);
                    if (last_chunk) count_q <= acc_q + CW'(chunk_cnt);
                end
                DONE: begin
                    if (out_ready) count_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign count     = count_q;

endmodule

// File: tb/tb_popcount_serial.sv
// Bench for popcount_serial: three configurations (15/3, 16/5, 15/15) on one clock.
module tb_popcount_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_in_valid, a_in_ready, a_cz, a_out_valid, a_out_ready;
    logic [14:0] a_data;
    logic [3:0]  a_count;

    logic        b_in_valid, b_in_ready, b_cz, b_out_valid, b_out_ready;
    logic [15:0] b_data;
    logic [4:0]  b_count;

    logic        c_in_valid, c_in_ready, c_cz, c_out_valid, c_out_ready;
    logic [14:0] c_data;
    logic [3:0]  c_count;

    int checks   = 0;
    int failures = 0;

    popcount_serial #(.WIDTH(15), .CHUNK(3)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .data(a_data), .count_zeros(a_cz), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .count(a_count)
    );

    popcount_serial #(.WIDTH(16), .CHUNK(5)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .data(b_data), .count_zeros(b_cz), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .count(b_count)
    );

    popcount_serial #(.WIDTH(15), .CHUNK(15)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .data(c_data), .count_zeros(c_cz), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .count(c_count)
    );

    // Reference: number of bits among the low w that differ from cz.
    function automatic int ref_pop(input logic [63:0] d, input int w, input bit cz);
        int n;
        n = 0;
        for (int i = 0; i < w; i++) if (d[i] != cz) n++;
        return n;
    endfunction

    task automatic op_a(input logic [14:0] d, input logic cz, output logic [3:0] cnt, output int lat);
        int w;
        w = 0;
        while (!a_in_ready && w < 40) begin @(negedge clk); w++; end
        a_data = d; a_cz = cz; a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0; a_data = 15'($urandom); a_cz = 1'($urandom);
        lat = 0;
        while (!a_out_valid && lat < 40) begin @(negedge clk); lat++; end
        cnt = a_count;
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
    endtask

    task automatic op_b(input logic [15:0] d, input logic cz, output logic [4:0] cnt, output int lat);
        int w;
        w = 0;
        while (!b_in_ready && w < 40) begin @(negedge clk); w++; end
        b_data = d; b_cz = cz; b_in_valid = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0; b_data = 16'($urandom); b_cz = 1'($urandom);
        lat = 0;
        while (!b_out_valid && lat < 40) begin @(negedge clk); lat++; end
        cnt = b_count;
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
    endtask

    task automatic op_c(input logic [14:0] d, input logic cz, output logic [3:0] cnt, output int lat);
        int w;
        w = 0;
        while (!c_in_ready && w < 40) begin @(negedge clk); w++; end
        c_data = d; c_cz = cz; c_in_valid = 1'b1;
        @(negedge clk);
        c_in_valid = 1'b0; c_data = 15'($urandom); c_cz = 1'($urandom);
        lat = 0;
        while (!c_out_valid && lat < 40) begin @(negedge clk); lat++; end
        cnt = c_count;
        c_out_ready = 1'b1;
        @(negedge clk);
        c_out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_in_valid = 1'b1; b_in_valid = 1'b1; c_in_valid = 1'b1;
        a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
        checks++;
        if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
        checks++;
        if (a_count !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", a_count); end
        checks++;
        if (b_out_valid !== 1'b0 || c_out_valid !== 1'b0 || b_count !== 5'd0 || c_count !== 4'd0) begin
            failures++; $display("FAIL reset_bc: got vld %b/%b cnt %0d/%0d expected 0", b_out_valid, c_out_valid, b_count, c_count);
        end
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        a_out_ready = 1'b0; b_out_ready = 1'b0; c_out_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_release: got rdy %b vld %b expected 1/0", a_in_ready, a_out_valid);
        end
    endtask

    task automatic test_latency;
        logic ev;
        a_data = 15'h7FFF; a_cz = 1'b0; a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0; a_data = 15'h0000; a_cz = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            ev = (k == 5);
            checks++;
            if (a_out_valid !== ev || a_in_ready !== 1'b0) begin
                failures++;
                $display("FAIL latency_cycle%0d: got vld %b rdy %b expected vld %b rdy 0", k, a_out_valid, a_in_ready, ev);
            end
        end
        checks++;
        if (a_count !== 4'd15) begin failures++; $display("FAIL latency_count: got %0d expected 15", a_count); end
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0 || a_count !== 4'd0) begin
            failures++; $display("FAIL after_done: got vld %b cnt %0d expected 0/0", a_out_valid, a_count);
        end
    endtask

    task automatic test_patterns;
        logic [3:0]  cnt;
        logic [14:0] d;
        logic        cz;
        int          lat;
        op_a(15'h0000, 1'b1, cnt, lat);
        checks++;
        if (cnt !== 4'd15) begin failures++; $display("FAIL zeros_of_0000: got %0d expected 15", cnt); end
        op_a(15'h5555, 1'b0, cnt, lat);
        checks++;
        if (cnt !== 4'd8) begin failures++; $display("FAIL ones_of_5555: got %0d expected 8", cnt); end
        for (int i = 0; i < 6; i++) begin
            d = 15'($urandom); cz = 1'($urandom);
            op_a(d, cz, cnt, lat);
            checks++;
            if (cnt !== 4'(ref_pop(d, 15, cz)) || lat != 5) begin
                failures++;
                $display("FAIL rand_a d=%h cz=%b: got cnt %0d lat %0d expected %0d lat 5", d, cz, cnt, lat, ref_pop(d, 15, cz));
            end
        end
    endtask

    task automatic test_hold;
        logic [14:0] d;
        int          w, exp;
        d = 15'($urandom);
        exp = ref_pop(d, 15, 1'b0);
        a_data = d; a_cz = 1'b0; a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0; a_data = ~d; a_cz = 1'b1;
        w = 0;
        while (!a_out_valid && w < 40) begin @(negedge clk); w++; end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (a_out_valid !== 1'b1 || a_count !== 4'(exp) || a_in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d: got vld %b cnt %0d rdy %b expected 1 %0d 0", k, a_out_valid, a_count, a_in_ready, exp);
            end
            @(negedge clk);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            failures++; $display("FAIL hold_release: got rdy %b vld %b expected 1/0", a_in_ready, a_out_valid);
        end
    endtask

    task automatic test_rst_mid;
        logic [3:0] cnt;
        int         lat;
        logic       seen;
        a_data = 15'h7FFF; a_cz = 1'b0; a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            failures++; $display("FAIL rst_mid_state: got rdy %b vld %b expected 1/0", a_in_ready, a_out_valid);
        end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (a_out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_pulse: got out_valid %b expected 0", seen); end
        op_a(15'h0001, 1'b0, cnt, lat);
        checks++;
        if (cnt !== 4'd1) begin failures++; $display("FAIL rst_mid_next: got %0d expected 1", cnt); end
    endtask

    task automatic test_padded;
        logic [4:0]  cnt;
        logic [15:0] d;
        logic        cz;
        int          lat;
        op_b(16'hFFFF, 1'b1, cnt, lat);
        checks++;
        if (cnt !== 5'd0 || lat != 4) begin failures++; $display("FAIL pad_zeros: got cnt %0d lat %0d expected 0 lat 4", cnt, lat); end
        op_b(16'hFFFF, 1'b0, cnt, lat);
        checks++;
        if (cnt !== 5'd16 || lat != 4) begin failures++; $display("FAIL pad_ones: got cnt %0d lat %0d expected 16 lat 4", cnt, lat); end
        for (int i = 0; i < 4; i++) begin
            d = 16'($urandom); cz = 1'($urandom);
            op_b(d, cz, cnt, lat);
            checks++;
            if (cnt !== 5'(ref_pop(d, 16, cz))) begin
                failures++; $display("FAIL rand_b d=%h cz=%b: got %0d expected %0d", d, cz, cnt, ref_pop(d, 16, cz));
            end
        end
    endtask

    task automatic test_full_chunk;
        logic [3:0]  cnt;
        logic [14:0] d;
        logic        cz;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            d = 15'($urandom); cz = 1'($urandom);
            op_c(d, cz, cnt, lat);
            checks++;
            if (cnt !== 4'(ref_pop(d, 15, cz)) || lat != 1) begin
                failures++;
                $display("FAIL full_chunk d=%h cz=%b: got cnt %0d lat %0d expected %0d lat 1", d, cz, cnt, lat, ref_pop(d, 15, cz));
            end
        end
    endtask

    task automatic test_back_to_back;
        int  qa[$];
        int  qc[$];
        int  exp;
        bit  drain;
        for (int cyc = 0; cyc < 640; cyc++) begin
            drain = (cyc >= 600);
            a_in_valid  = drain ? 1'b0 : 1'($urandom);
            a_data      = 15'($urandom);
            a_cz        = 1'($urandom);
            a_out_ready = drain ? 1'b1 : 1'($urandom);
            c_in_valid  = drain ? 1'b0 : 1'($urandom);
            c_data      = 15'($urandom);
            c_cz        = 1'($urandom);
            c_out_ready = drain ? 1'b1 : 1'($urandom);
            if (a_out_valid && a_out_ready) begin
                checks++;
                if (qa.size() == 0) begin
                    failures++; $display("FAIL b2b_a_unexpected: got count %0d expected no result", a_count);
                end else begin
                    exp = qa.pop_front();
                    if (a_count !== 4'(exp)) begin failures++; $display("FAIL b2b_a_count: got %0d expected %0d", a_count, exp); end
                end
            end
            if (a_in_valid && a_in_ready) begin
                checks++;
                if (qa.size() != 0 || a_out_valid) begin
                    failures++; $display("FAIL b2b_a_accept: got accept with %0d pending expected none", qa.size());
                end
                qa.push_back(ref_pop(a_data, 15, a_cz));
            end
            if (c_out_valid && c_out_ready) begin
                checks++;
                if (qc.size() == 0) begin
                    failures++; $display("FAIL b2b_c_unexpected: got count %0d expected no result", c_count);
                end else begin
                    exp = qc.pop_front();
                    if (c_count !== 4'(exp)) begin failures++; $display("FAIL b2b_c_count: got %0d expected %0d", c_count, exp); end
                end
            end
            if (c_in_valid && c_in_ready) begin
                checks++;
                if (qc.size() != 0 || c_out_valid) begin
                    failures++; $display("FAIL b2b_c_accept: got accept with %0d pending expected none", qc.size());
                end
                qc.push_back(ref_pop(c_data, 15, c_cz));
            end
            @(negedge clk);
        end
        a_out_ready = 1'b0; c_out_ready = 1'b0;
        checks++;
        if (qa.size() != 0 || qc.size() != 0) begin
            failures++; $display("FAIL b2b_drain: got %0d/%0d pending expected 0/0", qa.size(), qc.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_data = '0; a_cz = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_data = '0; b_cz = 1'b0; b_out_ready = 1'b0;
        c_in_valid = 1'b0; c_data = '0; c_cz = 1'b0; c_out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_patterns();
        test_hold();
        test_rst_mid();
        test_padded();
        test_full_chunk();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/popcount_serial.md
POPCOUNT_SERIAL -- requirements
Module: popcount_serial

Interface
REQ-001 Parameter WIDTH, default 15: number of input bits counted per operand; legal range 1..64.
REQ-002 Parameter CHUNK, default 3: bits counted per clock; legal range 1..WIDTH.
REQ-003 Derived constants: CW = clog2(WIDTH+1) is the count width; NCH = ceil(WIDTH/CHUNK) is the number of count cycles.
REQ-004 Port clk, input, 1: single clock; all state updates occur on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port in_valid, input, 1: operand present on data.
REQ-007 Port in_ready, output, 1: block accepts an operand this cycle.
REQ-008 Port data, input, WIDTH: operand vector.
REQ-009 Port count_zeros, input, 1: mode select sampled with data; 1 = count zero bits, 0 = count one bits.
REQ-010 Port out_valid, output, 1: result present on count.
REQ-011 Port out_ready, input, 1: consumer accepts the result.
REQ-012 Port count, output, CW: number of counted bits in the accepted operand.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, COUNT and DONE.
REQ-014 IDLE: in_ready=1 and out_valid=0; in_valid=1 latches data (bitwise inverted if count_zeros=1), clears accumulator and chunk index, and moves to COUNT.
REQ-015 Accept SHALL occur only when in_valid and in_ready are both 1; in_ready SHALL be 0 in COUNT and DONE.
REQ-016 COUNT: each cycle adds the popcount of operand bits [idx*CHUNK +: CHUNK] to the accumulator, then increments idx.
REQ-017 Bit positions at or above WIDTH in the final partial chunk SHALL count as 0 in both modes.
REQ-018 After chunk NCH-1 is added, the FSM SHALL move to DONE.
REQ-019 Latency: if accept occurs on edge T, out_valid SHALL be 1 from edge T+NCH.
REQ-020 DONE: out_valid=1 and count holds the final sum; count and out_valid SHALL stay stable while out_ready=0.
REQ-021 DONE with out_ready=1: the FSM SHALL return to IDLE on that edge; a new accept is possible on the next cycle at the earliest.
REQ-022 The accumulator SHALL be CW bits wide; the maximum result WIDTH SHALL never overflow it.
REQ-023 The count output SHALL be driven from a register; it SHALL read 0 outside DONE.
REQ-024 data and count_zeros changing after accept SHALL NOT affect the result in flight.
REQ-025 For CHUNK=WIDTH, NCH=1 and the result SHALL appear one cycle after accept.

Reset
REQ-026 With rst=1 on a clock edge: FSM to IDLE, accumulator, idx, operand register and count to 0, out_valid to 0, in_ready to 1 from the following cycle.
REQ-027 rst SHALL take priority over every handshake, including in_valid=1 in IDLE and out_ready=1 in DONE.
REQ-028 rst asserted mid-COUNT or in DONE SHALL discard the operation in flight, with no out_valid pulse afterwards.

Structure
REQ-029 The state typedef (IDLE, COUNT, DONE) and the clog2/ceil-divide helper functions SHALL live in the shared package popcount_pkg.
REQ-030 Per-cycle bit counting SHALL be a combinational sub-module popcount_chunk, parametrised by CHUNK, with a clog2(CHUNK+1)-bit output.
REQ-031 popcount_serial SHALL contain only the FSM, the operand register, the accumulator, the index counter and a single popcount_chunk instance.

Verification
REQ-032 WIDTH=15, CHUNK=3, data=15'h7FFF, count_zeros=0 -> out_valid exactly 5 cycles after accept, count=15.
REQ-033 WIDTH=15, CHUNK=3, data=15'h0000, count_zeros=1 -> count=15; data=15'h5555, count_zeros=0 -> count=8.
REQ-034 out_ready held 0 for 10 cycles in DONE -> count and out_valid constant throughout and in_ready=0; out_ready=1 -> IDLE and in_ready=1 the next cycle.
REQ-035 rst pulsed on the 2nd COUNT cycle -> out_valid never asserts, in_ready=1 the cycle after reset, and the next operand 15'h0001 yields count=1.
REQ-036 WIDTH=16, CHUNK=5 (NCH=4, padded last chunk), data=16'hFFFF with count_zeros=1 -> count=0, and with count_zeros=0 -> count=16, latency 4 cycles.
REQ-037 Back-to-back random operands with random out_ready (WIDTH=15, CHUNK=3 and CHUNK=15) -> every count matches a reference popcount, and no accept occurs outside IDLE.
